// File: rtl/cpu_control_if.sv
// Fetch and ALU-select bus between the cpu_control sequencer (master)
// and the instruction memory / ALU side (slave).
interface cpu_control_if #(
  parameter int PC_W = 4
);
  logic [PC_W-1:0] imem_addr;
  logic            imem_req;
  logic            imem_ack;
  logic [7:0]      imem_data;
  logic [2:0]      alu_sel;
  logic            alu_zero;
  logic            alu_carry;

  modport master (
    output imem_addr, imem_req, alu_sel,
    input  imem_ack, imem_data, alu_zero, alu_carry
  );

  modport slave (
    input  imem_addr, imem_req, alu_sel,
    output imem_ack, imem_data, alu_zero, alu_carry
  );
endinterface

// File: rtl/cpu_control.sv
// Fetch/decode/execute sequencer for the 4-bit mini CPU.
// Optional single-step PAUSE state is enabled by defining CTRL_SINGLE_STEP_EN.
module cpu_control #(
  parameter int         PC_W    = 4,
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input  logic            clk,
  input  logic            rst,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic            step,
`endif
  cpu_control_if.master   bus,
  output logic            r0_we,
  output logic            r1_we,
  output logic [1:0]      wb_sel,
  output logic [3:0]      imm,
  output logic [PC_W-1:0] pc,
  output logic            flag_z,
  output logic            flag_c,
  output logic            halted
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    HALT
`ifdef CTRL_SINGLE_STEP_EN
    , PAUSE
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic            flag_z_q, flag_z_d;
  logic            flag_c_q, flag_c_d;
  logic [3:0]      opcode;
  logic [2:0]      alu_code;
  logic [PC_W-1:0] jump_target;

  assign opcode      = ir_q[7:4];
  assign jump_target = PC_W'(ir_q[3:0]);

  assign imm           = ir_q[3:0];
  assign pc            = pc_q;
  assign flag_z        = flag_z_q;
  assign flag_c        = flag_c_q;
  assign bus.imem_addr = pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      ir_q     <= 8'h00;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
    end
  end

  // ALU select for the five arithmetic/logic opcodes; 3'b111 means "no ALU op".
  always_comb begin
    alu_code = 3'b111;
    case (opcode)
      4'h0:    alu_code = 3'b000;
      4'h1:    alu_code = 3'b001;
      4'h2:    alu_code = 3'b010;
      4'h3:    alu_code = 3'b011;
      4'h4:    alu_code = 3'b100;
      default: alu_code = 3'b111;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    flag_z_d     = flag_z_q;
    flag_c_d     = flag_c_q;
    bus.imem_req = 1'b0;
    bus.alu_sel  = 3'b111;
    r0_we        = 1'b0;
    r1_we        = 1'b0;
    wb_sel       = 2'b00;
    halted       = 1'b0;

    case (state_q)
      IDLE: state_d = FETCH;

      FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ack) begin
          ir_d    = bus.imem_data;
          pc_d    = pc_q + PC_W'(1);
          state_d = DECODE;
        end
      end

      DECODE: begin
        bus.alu_sel = alu_code;
        state_d     = EXEC;
      end

      // Jumps test the flags registered before this edge, not the live ALU outputs.
      EXEC: begin
        bus.alu_sel = alu_code;
`ifdef CTRL_SINGLE_STEP_EN
        state_d     = PAUSE;
`else
        state_d     = FETCH;
`endif
        if (opcode == HALT_OP) begin
          state_d = HALT;
        end else begin
          case (opcode)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4: begin
              r0_we    = 1'b1;
              wb_sel   = 2'b00;
              flag_z_d = bus.alu_zero;
              flag_c_d = bus.alu_carry;
            end
            4'h5: begin
              r0_we  = 1'b1;
              wb_sel = 2'b01;
            end
            4'h6: begin
              r1_we  = 1'b1;
              wb_sel = 2'b01;
            end
            4'h7: begin
              r1_we  = 1'b1;
              wb_sel = 2'b10;
            end
            4'h8: pc_d = jump_target;
            4'h9: if (flag_z_q) pc_d = jump_target;
            4'hA: if (flag_c_q) pc_d = jump_target;
            default: ;
          endcase
        end
      end

      HALT: halted = 1'b1;

`ifdef CTRL_SINGLE_STEP_EN
      PAUSE: if (step) state_d = FETCH;
`endif

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_control.sv
// Directed, table-driven bench for cpu_control: per-cycle vectors of inputs
// and the hand-computed outputs expected after the following clock edge.
module tb_cpu_control;

  typedef struct packed {
    logic       rst;
    logic       ack;
    logic [7:0] data;
    logic       zero;
    logic       carry;
  } ins_t;

  typedef struct packed {
    logic       req;
    logic [3:0] addr;
    logic [2:0] alu;
    logic       r0;
    logic       r1;
    logic [1:0] wb;
    logic [3:0] imm;
    logic [3:0] pc;
    logic       z;
    logic       c;
    logic       h;
  } outs_t;

  typedef struct {
    string name;
    ins_t  stim;
    outs_t want;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       step;
  logic       r0_we, r1_we;
  logic [1:0] wb_sel;
  logic [3:0] imm, pc;
  logic       flag_z, flag_c, halted;

  int compared   = 0;
  int mismatched = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  cpu_control_if #(.PC_W(4)) bus ();

  cpu_control #(.PC_W(4), .HALT_OP(4'hF)) dut (
    .clk    (clk),
    .rst    (rst),
`ifdef CTRL_SINGLE_STEP_EN
    .step   (step),
`endif
    .bus    (bus),
    .r0_we  (r0_we),
    .r1_we  (r1_we),
    .wb_sel (wb_sel),
    .imm    (imm),
    .pc     (pc),
    .flag_z (flag_z),
    .flag_c (flag_c),
    .halted (halted)
  );

  function automatic ins_t mkIn(logic r, logic a, logic [7:0] d, logic z, logic c);
    return '{r, a, d, z, c};
  endfunction

  // imem_addr always mirrors pc, so one argument fills both fields.
  function automatic outs_t mkOut(logic req, logic [2:0] alu, logic r0, logic r1,
                                  logic [1:0] wb, logic [3:0] im, logic [3:0] p,
                                  logic z, logic c, logic h);
    return '{req, p, alu, r0, r1, wb, im, p, z, c, h};
  endfunction

  function automatic void add(string n, ins_t s, outs_t w);
    vq.push_back('{n, s, w});
  endfunction

  task automatic applyStimulus(input ins_t s);
    rst           = s.rst;
    bus.imem_ack  = s.ack;
    bus.imem_data = s.data;
    bus.alu_zero  = s.zero;
    bus.alu_carry = s.carry;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input outs_t want);
    outs_t got;
    got = {bus.imem_req, bus.imem_addr, bus.alu_sel, r0_we, r1_we, wb_sel,
           imm, pc, flag_z, flag_c, halted};
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, got, want);
    end
  endtask

  initial begin
    rst           = 1'b1;
    step          = 1'b0;
    bus.imem_ack  = 1'b0;
    bus.imem_data = 8'h00;
    bus.alu_zero  = 1'b0;
    bus.alu_carry = 1'b0;
    @(negedge clk);

`ifdef CTRL_SINGLE_STEP_EN
    applyStimulus(mkIn(1, 0, 8'h00, 0, 0));
    checkOutput("ss_reset", mkOut(0, 7, 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(mkIn(0, 1, 8'hFF, 0, 0));
    checkOutput("ss_fetch0", mkOut(1, 7, 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(mkIn(0, 1, 8'h53, 0, 0));
    checkOutput("ss_decode", mkOut(0, 7, 0, 0, 0, 3, 1, 0, 0, 0));
    applyStimulus(mkIn(0, 1, 8'hFF, 0, 0));
    checkOutput("ss_exec", mkOut(0, 7, 1, 0, 1, 3, 1, 0, 0, 0));
    for (int k = 0; k < 4; k++) begin
      applyStimulus(mkIn(0, 1, 8'hFF, 0, 0));
      checkOutput($sformatf("ss_pause%0d", k), mkOut(0, 7, 0, 0, 0, 3, 1, 0, 0, 0));
    end
    step = 1'b1;
    applyStimulus(mkIn(0, 0, 8'hFF, 0, 0));
    step = 1'b0;
    checkOutput("ss_fetch1", mkOut(1, 7, 0, 0, 0, 3, 1, 0, 0, 0));
`else
    // LDI0 3, LDI1 5, ADD, HALT with ack every cycle
    add("p1_reset",   mkIn(1, 0, 8'h00, 0, 0), mkOut(0, 7, 0, 0, 0, 0, 0, 0, 0, 0));
    add("p1_fetch0",  mkIn(0, 1, 8'hFF, 0, 0), mkOut(1, 7, 0, 0, 0, 0, 0, 0, 0, 0));
    add("p1_dec_ld0", mkIn(0, 1, 8'h53, 0, 0), mkOut(0, 7, 0, 0, 0, 3, 1, 0, 0, 0));
    add("p1_exe_ld0", mkIn(0, 1, 8'hFF, 0, 0), mkOut(0, 7, 1, 0, 1, 3, 1, 0, 0, 0));
    add("p1_fetch1",  mkIn(0, 1, 8'hFF, 0, 0), mkOut(1, 7, 0, 0, 0, 3, 1, 0, 0, 0));
    add("p1_dec_ld1", mkIn(0, 1, 8'h65, 0, 0), mkOut(0, 7, 0, 0, 0, 5, 2, 0, 0, 0));
    add("p1_exe_ld1", mkIn(0, 1, 8'hFF, 0, 0), mkOut(0, 7, 0, 1, 1, 5, 2, 0, 0, 0));
    add("p1_fetch2",  mkIn(0, 1, 8'hFF, 0, 0), mkOut(1, 7, 0, 0, 0, 5, 2, 0, 0, 0));
    add("p1_dec_add", mkIn(0, 1, 8'h00, 0, 0), mkOut(0, 0, 0, 0, 0, 0, 3, 0, 0, 0));
    add("p1_exe_add", mkIn(0, 1, 8'hFF, 1, 1), mkOut(0, 0, 1, 0, 0, 0, 3, 0, 0, 0));
    add("p1_fetch3",  mkIn(0, 1, 8'hFF, 0, 1), mkOut(1, 7, 0, 0, 0, 0, 3, 0, 1, 0));
    add("p1_dec_hlt", mkIn(0, 1, 8'hF0, 0, 0), mkOut(0, 7, 0, 0, 0, 0, 4, 0, 1, 0));
    add("p1_exe_hlt", mkIn(0, 1, 8'hFF, 0, 0), mkOut(0, 7, 0, 0, 0, 0, 4, 0, 1, 0));
    add("p1_halt13",  mkIn(0, 1, 8'hFF, 0, 0), mkOut(0, 7, 0, 0, 0, 0, 4, 0, 1, 1));
    add("p1_halt14",  mkIn(0, 1, 8'h53, 1, 1), mkOut(0, 7, 0, 0, 0, 0, 4, 0, 1, 1));
    // ADD sets z/c, JZ 7 taken, JC 9 taken, JMP 3, SUB clears flags, JZ 7 not taken
    add("p2_reset",   mkIn(1, 0, 8'h00, 0, 0), mkOut(0, 7, 0, 0, 0, 0, 0, 0, 0, 0));
    add("p2_fetch0",  mkIn(0, 1, 8'hFF, 0, 0), mkOut(1, 7, 0, 0, 0, 0, 0, 0, 0, 0));
    add("p2_dec_add", mkIn(0, 1, 8'h00, 0, 0), mkOut(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    add("p2_exe_add", mkIn(0, 0, 8'hFF, 0, 0), mkOut(0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
    add("p2_fetch1",  mkIn(0, 0, 8'hFF, 1, 1), mkOut(1, 7, 0, 0, 0, 0, 1, 1, 1, 0));
    add("p2_dec_jz",  mkIn(0, 1, 8'h97, 0, 0), mkOut(0, 7, 0, 0, 0, 7, 2, 1, 1, 0));
    add("p2_exe_jz",  mkIn(0, 1, 8'hFF, 0, 0), mkOut(0, 7, 0, 0, 0, 7, 2, 1, 1, 0));
    add("p2_jz_take", mkIn(0, 1, 8'hFF, 0, 0), mkOut(1, 7, 0, 0, 0, 7, 7, 1, 1, 0));
    add("p2_dec_jc",  mkIn(0, 1, 8'hA9, 0, 0), mkOut(0, 7, 0, 0, 0, 9, 8, 1, 1, 0));
    add("p2_exe_jc",  mkIn(0, 1, 8'hFF, 0, 0), mkOut(0, 7, 0, 0, 0, 9, 8, 1, 1, 0));
    add("p2_jc_take", mkIn(0, 1, 8'hFF, 0, 0), mkOut(1, 7, 0, 0, 0, 9, 9, 1, 1, 0));
    add("p2_dec_jmp", mkIn(0, 1, 8'h83, 0, 0), mkOut(0, 7, 0, 0, 0, 3, 10, 1, 1, 0));
    add("p2_exe_jmp", mkIn(0, 1, 8'hFF, 0, 0), mkOut(0, 7, 0, 0, 0, 3, 10, 1, 1, 0));
    add("p2_jmp_pc3", mkIn(0, 1, 8'hFF, 0, 0), mkOut(1, 7, 0, 0, 0, 3, 3, 1, 1, 0));
    add("p2_dec_sub", mkIn(0, 1, 8'h10, 0, 0), mkOut(0, 1, 0, 0, 0, 0, 4, 1, 1, 0));
    add("p2_exe_sub", mkIn(0, 1, 8'hFF, 0, 0), mkOut(0, 1, 1, 0, 0, 0, 4, 1, 1, 0));
    add("p2_sub_flg", mkIn(0, 1, 8'hFF, 0, 0), mkOut(1, 7, 0, 0, 0, 0, 4, 0, 0, 0));
    add("p2_dec_jz2", mkIn(0, 1, 8'h97, 1, 1), mkOut(0, 7, 0, 0, 0, 7, 5, 0, 0, 0));
    add("p2_exe_jz2", mkIn(0, 1, 8'hFF, 1, 1), mkOut(0, 7, 0, 0, 0, 7, 5, 0, 0, 0));
    add("p2_jz_seq",  mkIn(0, 1, 8'hFF, 1, 1), mkOut(1, 7, 0, 0, 0, 7, 5, 0, 0, 0));
    // MOV at pc0, then a 4-cycle ack stall at pc1 before LDI0 A
    add("p3_reset",   mkIn(1, 0, 8'h00, 0, 0), mkOut(0, 7, 0, 0, 0, 0, 0, 0, 0, 0));
    add("p3_fetch0",  mkIn(0, 1, 8'hFF, 0, 0), mkOut(1, 7, 0, 0, 0, 0, 0, 0, 0, 0));
    add("p3_dec_mov", mkIn(0, 1, 8'h70, 0, 0), mkOut(0, 7, 0, 0, 0, 0, 1, 0, 0, 0));
    add("p3_exe_mov", mkIn(0, 1, 8'hFF, 0, 0), mkOut(0, 7, 0, 1, 2, 0, 1, 0, 0, 0));
    add("p3_fetch1",  mkIn(0, 1, 8'hFF, 0, 0), mkOut(1, 7, 0, 0, 0, 0, 1, 0, 0, 0));
    add("p3_stall0",  mkIn(0, 0, 8'hF0, 0, 0), mkOut(1, 7, 0, 0, 0, 0, 1, 0, 0, 0));
    add("p3_stall1",  mkIn(0, 0, 8'hF1, 0, 0), mkOut(1, 7, 0, 0, 0, 0, 1, 0, 0, 0));
    add("p3_stall2",  mkIn(0, 0, 8'hF2, 0, 0), mkOut(1, 7, 0, 0, 0, 0, 1, 0, 0, 0));
    add("p3_stall3",  mkIn(0, 0, 8'hF3, 0, 0), mkOut(1, 7, 0, 0, 0, 0, 1, 0, 0, 0));
    add("p3_dec_ld0", mkIn(0, 1, 8'h5A, 0, 0), mkOut(0, 7, 0, 0, 0, 10, 2, 0, 0, 0));
    add("p3_exe_ld0", mkIn(0, 0, 8'hFF, 0, 0), mkOut(0, 7, 1, 0, 1, 10, 2, 0, 0, 0));
    add("p3_fetch2",  mkIn(0, 0, 8'hFF, 0, 0), mkOut(1, 7, 0, 0, 0, 10, 2, 0, 0, 0));
    // Reset while an ADD sits in DECODE
    add("p4_dec_add", mkIn(0, 1, 8'h00, 0, 0), mkOut(0, 0, 0, 0, 0, 0, 3, 0, 0, 0));
    add("p4_rst_dec", mkIn(1, 1, 8'hFF, 1, 1), mkOut(0, 7, 0, 0, 0, 0, 0, 0, 0, 0));
    add("p4_refetch", mkIn(0, 0, 8'hFF, 1, 1), mkOut(1, 7, 0, 0, 0, 0, 0, 0, 0, 0));

    for (int k = 0; k < vq.size(); k++) begin
      applyStimulus(vq[k].stim);
      checkOutput(vq[k].name, vq[k].want);
    end

    // PC wrap: 16 NOPs from pc=0 with ALU outputs held high
    applyStimulus(mkIn(1, 0, 8'h00, 0, 0));
    checkOutput("wrap_reset", mkOut(0, 7, 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(mkIn(0, 1, 8'hFF, 1, 1));
    checkOutput("wrap_fetch0", mkOut(1, 7, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 16; i++) begin
      logic [3:0] nxt;
      nxt = 4'(i + 1);
      applyStimulus(mkIn(0, 1, 8'hB0, 1, 1));
      checkOutput($sformatf("wrap_dec%0d", i), mkOut(0, 7, 0, 0, 0, 0, nxt, 0, 0, 0));
      applyStimulus(mkIn(0, 1, 8'hFF, 1, 1));
      checkOutput($sformatf("wrap_exe%0d", i), mkOut(0, 7, 0, 0, 0, 0, nxt, 0, 0, 0));
      applyStimulus(mkIn(0, 1, 8'hFF, 1, 1));
      checkOutput($sformatf("wrap_fetch%0d", i), mkOut(1, 7, 0, 0, 0, 0, nxt, 0, 0, 0));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cpu_control.md
Name: cpu_control

Overview:
- Fetch/decode/execute sequencer for the 4-bit mini CPU; it is the control-side driver of the ALU interface.
- Fetches 8-bit instructions over a req/ack handshake, decodes them, and drives `alu_sel` to the ALU.
- Drives register-file write enables and the writeback mux select, and keeps the PC plus registered zero/carry flags.
- Register file, ALU and instruction memory are external.

Parameters:
- PC_W, 4, program counter width; PC wraps modulo 2^PC_W.
- HALT_OP, 4'hF, opcode that enters HALT.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- imem_addr  out  PC_W  fetch address (equals pc)
- imem_req  out  1  fetch request
- imem_ack  in  1  instruction valid; sampled only in FETCH
- imem_data  in  8  instruction: [7:4] opcode, [3:0] imm
- alu_sel  out  3  ALU operation select
- alu_zero  in  1  ALU zero output
- alu_carry  in  1  ALU carry output
- r0_we  out  1  R0 write enable, 1-cycle pulse
- r1_we  out  1  R1 write enable, 1-cycle pulse
- wb_sel  out  2  writeback source: 00 ALU result, 01 imm, 10 R0
- imm  out  4  immediate field of IR
- pc  out  PC_W  program counter
- flag_z  out  1  registered zero flag
- flag_c  out  1  registered carry flag
- halted  out  1  high in HALT

Behaviour:

Reset values (rst high at a clock edge):
- state=IDLE, pc=0, IR=8'h00, flag_z=0, flag_c=0.
- Outputs: imem_req=0, r0_we=0, r1_we=0, wb_sel=00, alu_sel=3'b111, halted=0.
- Reset overrides every state, including mid-FETCH with an ack pending and HALT.

States and transitions (outputs are Moore-decoded from state and IR):
- IDLE: go to FETCH unconditionally.
- FETCH: imem_req=1, imem_addr=pc.
  - On imem_ack=1: IR<=imem_data, pc<=pc+1, go to DECODE.
  - An ack in the first FETCH cycle is legal, giving 1-cycle fetch.
  - Otherwise stay in FETCH, with req held and addr stable.
- DECODE: 1 cycle; alu_sel driven from IR; go to EXEC.
- EXEC: 1 cycle; write enables and flag/PC updates per opcode; go to FETCH, or to HALT for HALT_OP.
- HALT: halted=1, imem_req=0; remain until rst.
- Minimum 3 cycles per instruction: FETCH, DECODE, EXEC.

Opcode decode. alu_sel is valid in both DECODE and EXEC; it is 3'b111 in all other states and for non-ALU opcodes.
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR:
  - alu_sel=000/001/010/011/100 respectively.
  - In EXEC: r0_we=1, wb_sel=00, flag_z<=alu_zero, flag_c<=alu_carry.
- 5 LDI0: r0_we=1, wb_sel=01.
- 6 LDI1: r1_we=1, wb_sel=01.
- 7 MOV: r1_we=1, wb_sel=10 (R1<=R0).
- 8 JMP: pc<=imm zero-extended to PC_W, or truncated to PC_W if PC_W<4.
- 9 JZ: pc<=imm if flag_z=1, else pc unchanged (already incremented).
- A JC: as JZ, using flag_c.
- F (HALT_OP): go to HALT; no write.
- All other opcodes: NOP, with no writes and no flag change.

Boundary rules:
- Flags change only on ALU opcodes; loads, moves and jumps leave them intact.
- Jump conditions use the flag values held before the current EXEC edge.
- PC increment wraps from 2^PC_W-1 to 0.
- imem_ack outside FETCH is ignored. imem_data is sampled only on the accepting edge.
- At most one of r0_we/r1_we is high in any cycle, and only in EXEC.

Optional Feature:
- Macro: CTRL_SINGLE_STEP_EN.
- Defined:
  - Adds input port `step` (1 bit).
  - Adds state PAUSE, entered from EXEC instead of FETCH.
  - PAUSE holds all outputs at their idle values and moves to FETCH on the first cycle with step=1.
  - HALT_OP still goes directly to HALT.
  - rst clears PAUSE to IDLE.
- Undefined: no `step` port and no PAUSE state; EXEC goes straight to FETCH.

Test Plan:
- Reset, then FETCH with imem_ack=1 every cycle and program {LDI0 3 (8'h53), LDI1 5 (8'h65), ADD (8'h00), HALT (8'hF0)} -> r0_we pulses in the EXECs of instrs 1 and 3, wb_sel=01 then 00; alu_sel=000 in DECODE/EXEC of ADD; halted=1 from the 13th cycle after reset release; pc=4.
- ADD with alu_carry=1, alu_zero=1 driven during EXEC, then JZ 2 (8'h92) -> flag_z=1, flag_c=1; pc becomes 2 after JZ EXEC. Repeat with alu_zero=0 -> pc advances sequentially.
- imem_ack held low for 4 cycles in FETCH at pc=1 -> imem_req=1 and imem_addr=1 stable throughout; IR loads only on the ack edge.
- PC wrap: PC_W=4, 16 NOP (8'h B0) fetches from pc=0 -> pc returns to 0, flags unchanged, no write enables.
- Assert rst for 1 cycle while in DECODE of an ADD -> next cycle all outputs at reset values; no r0_we pulse; pc=0; fetch restarts at address 0.
- CTRL_SINGLE_STEP_EN defined, step=0 -> stuck in PAUSE after first EXEC with imem_req=0; a step pulse -> FETCH of pc=1 next cycle.
